// File: rtl/spectrum_bar_if.sv
// spectrum_bar_if: pixel timing, bin-write and colour signals of the
// spectrum bar renderer, bundled as one interface. The renderer connects
// through the slave modport; whatever drives pixels and bins uses master.
//
// Write protocol: bin_wr is a single-cycle strobe with no back-pressure.
// bin_addr/bin_mag are sampled on every rising clk edge where bin_wr=1, and
// the renderer always accepts the write (there is no ready signal). Writes
// with bin_addr >= BINS are silently discarded.
interface spectrum_bar_if #(
  parameter int BINS  = 16,
  parameter int MAG_W = 16,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
);
  localparam int AW = $clog2(BINS);

  logic [X_W-1:0]   x_px;
  logic [Y_W-1:0]   y_px;
  logic             activevideo;
  logic             vsync;
  logic             bin_wr;
  logic [AW-1:0]    bin_addr;
  logic [MAG_W-1:0] bin_mag;
  logic             swap_pulse;
  logic             busy;
  logic             r;
  logic             g;
  logic             b;
  logic [1:0]       dbg_state;  // FSM state: 0 idle, 1 swap, 2 peak update

  modport master (
    output x_px, y_px, activevideo, vsync, bin_wr, bin_addr, bin_mag,
    input  swap_pulse, busy, r, g, b, dbg_state
  );

  modport slave (
    input  x_px, y_px, activevideo, vsync, bin_wr, bin_addr, bin_mag,
    output swap_pulse, busy, r, g, b, dbg_state
  );
endinterface

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: draws one horizontal bar per frequency bin.
// Magnitudes are written into a back bank and become visible when the banks
// swap on a vsync rising edge. Pixel path is two registered stages.
// Optional feature macro: PEAK_HOLD_EN builds per-bin peak-hold registers,
// the post-swap peak update walk and red peak markers.
module spectrum_bar_renderer #(
  parameter int              BINS      = 16,
  parameter int              MAG_W     = 16,
  parameter int              X_W       = 10,
  parameter int              Y_W       = 10,
  parameter int              BAR_SHIFT = 4,
  parameter int              MAG_SHIFT = 0,
  parameter logic [MAG_W-1:0] DECAY    = 1
) (
  input logic           clk,
  input logic           reset_n,
  spectrum_bar_if.slave bus
);
  localparam int AW     = $clog2(BINS);
  localparam int BW     = Y_W - BAR_SHIFT;
  localparam int CW     = (X_W > MAG_W) ? X_W : MAG_W;
  localparam int LAST_I = BINS - 1;
  localparam logic [AW-1:0] LAST_IDX = LAST_I[AW-1:0];
  localparam logic [AW:0]   BINS_A   = BINS[AW:0];
  localparam logic [BW:0]   BINS_Y   = BINS[BW:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWAP   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;      // bank currently displayed (front)
  logic          pend_q, pend_d;    // vsync edge waiting for the FSM
  logic [AW-1:0] idx_q, idx_d;      // peak walk position
  logic          vsync_q;
  logic          swap_pulse_q;

  logic [MAG_W-1:0] bank_q [2][BINS];

  logic vs_rise;
  logic wr_ok;
  logic wr_bank;

  assign vs_rise = bus.vsync & ~vsync_q;
  assign wr_ok   = bus.bin_wr && ({1'b0, bus.bin_addr} < BINS_A);
  // In the swap cycle the select is about to flip, so the bank that becomes
  // the back bank is the one being displayed right now.
  assign wr_bank = (state_q == SWAP) ? sel_q : ~sel_q;

  // Next-state logic for swap sequencing and pending-edge capture
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (vs_rise || pend_q) begin
          state_d = SWAP;
          pend_d  = 1'b0;
        end
      end
      SWAP: begin
        sel_d = ~sel_q;
        if (vs_rise) pend_d = 1'b1;
`ifdef PEAK_HOLD_EN
        state_d = UPDATE;
        idx_d   = '0;
`else
        state_d = IDLE;
`endif
      end
      UPDATE: begin
        if (vs_rise) pend_d = 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PEAK_HOLD_EN
  logic busy_q;
  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  // FSM state, bank select and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      pend_q       <= 1'b0;
      idx_q        <= '0;
      vsync_q      <= 1'b0;
      swap_pulse_q <= 1'b0;
`ifdef PEAK_HOLD_EN
      busy_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      idx_q        <= idx_d;
      vsync_q      <= bus.vsync;
      swap_pulse_q <= (state_d == SWAP);
`ifdef PEAK_HOLD_EN
      busy_q       <= (state_d == UPDATE);
`endif
    end
  end

  // Magnitude banks: host writes land in the back bank
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < BINS; i++)
          bank_q[k][i] <= '0;
    end else if (wr_ok) begin
      bank_q[wr_bank][bus.bin_addr] <= bus.bin_mag;
    end
  end

  // Pixel stage 1 decode: which bar, and is this pixel outside every bar
  logic [BW-1:0]        y_bin;
  logic [BAR_SHIFT-1:0] y_row;
  logic                 y_in_range;
  logic [AW-1:0]        rd_idx;
  logic                 blank_s0;

  assign y_bin      = bus.y_px[Y_W-1:BAR_SHIFT];
  assign y_row      = bus.y_px[BAR_SHIFT-1:0];
  assign y_in_range = ({1'b0, y_bin} < BINS_Y);
  assign rd_idx     = y_in_range ? y_bin[AW-1:0] : '0;
  assign blank_s0   = !bus.activevideo || !y_in_range || (y_row == '0);

  logic             s1_blank_q;
  logic [X_W-1:0]   s1_x_q;
  logic [MAG_W-1:0] s1_mag_q;

`ifdef PEAK_HOLD_EN
  logic [MAG_W-1:0] peak_q [BINS];
  logic [MAG_W-1:0] s1_peak_q;
  logic [MAG_W-1:0] walk_front, walk_dec, walk_new;

  // The walk runs after the select flip, so bank_q[sel_q] is the new front.
  assign walk_front = bank_q[sel_q][idx_q];
  assign walk_dec   = (peak_q[idx_q] >= DECAY) ? (peak_q[idx_q] - DECAY) : '0;
  assign walk_new   = (walk_front > walk_dec) ? walk_front : walk_dec;

  // Peak registers: one bin refreshed per cycle of the update walk
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BINS; i++) peak_q[i] <= '0;
    end else if (state_q == UPDATE) begin
      peak_q[idx_q] <= walk_new;
    end
  end

  // Stage 1 peak read for display (bins not yet walked show old peaks)
  always_ff @(posedge clk) begin
    if (!reset_n) s1_peak_q <= '0;
    else          s1_peak_q <= peak_q[rd_idx];
  end
`endif

  // Stage 1 register: front bank read and decoded blanking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_blank_q <= 1'b1;
      s1_x_q     <= '0;
      s1_mag_q   <= '0;
    end else begin
      s1_blank_q <= blank_s0;
      s1_x_q     <= bus.x_px;
      s1_mag_q   <= bank_q[sel_q][rd_idx];
    end
  end

  // Stage 2 compare: common width so oversized magnitudes give full bars
  logic [CW-1:0] x_ext, scaled;
  logic          bar_hit, peak_hit;

  assign x_ext   = CW'(s1_x_q);
  assign scaled  = CW'(s1_mag_q >> MAG_SHIFT);
  assign bar_hit = (x_ext < scaled);
`ifdef PEAK_HOLD_EN
  assign peak_hit = (x_ext == CW'(s1_peak_q >> MAG_SHIFT)) && (s1_peak_q != '0);
`else
  assign peak_hit = 1'b0;
`endif

  logic r_q, g_q, b_q;

  // Stage 2 register: colour with peak marker taking precedence over bar
  always_ff @(posedge clk) begin
    if (!reset_n || s1_blank_q) begin
      r_q <= 1'b0;
      g_q <= 1'b0;
      b_q <= 1'b0;
    end else if (peak_hit) begin
      r_q <= 1'b1;
      g_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      r_q <= bar_hit;
      g_q <= bar_hit;
      b_q <= bar_hit;
    end
  end

  assign bus.r          = r_q;
  assign bus.g          = g_q;
  assign bus.b          = b_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// tb_spectrum_bar_renderer: table vectors, hand sequences and randomized
// pixel streams checked against a frame-level model of the bar display.
module tb_spectrum_bar_renderer;
  localparam int BINS      = 16;
  localparam int MAG_W     = 16;
  localparam int X_W       = 10;
  localparam int Y_W       = 10;
  localparam int BAR_SHIFT = 4;
  localparam int MAG_SHIFT = 0;
  localparam int DECAY     = 1;
  localparam int AW        = $clog2(BINS);
`ifdef PEAK_HOLD_EN
  localparam int EXP_BUSY  = BINS;
`else
  localparam int EXP_BUSY  = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spectrum_bar_if #(.BINS(BINS), .MAG_W(MAG_W), .X_W(X_W), .Y_W(Y_W)) bus ();
  spectrum_bar_if #(.BINS(12), .MAG_W(MAG_W), .X_W(X_W), .Y_W(Y_W)) bus12 ();

  spectrum_bar_renderer #(
    .BINS(BINS), .MAG_W(MAG_W), .X_W(X_W), .Y_W(Y_W),
    .BAR_SHIFT(BAR_SHIFT), .MAG_SHIFT(MAG_SHIFT), .DECAY(16'(DECAY))
  ) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  spectrum_bar_renderer #(
    .BINS(12), .MAG_W(MAG_W), .X_W(X_W), .Y_W(Y_W),
    .BAR_SHIFT(BAR_SHIFT), .MAG_SHIFT(MAG_SHIFT), .DECAY(16'(DECAY))
  ) u_dut12 (.clk(clk), .reset_n(reset_n), .bus(bus12));

  // ---------------- model and scoreboard ----------------
  int m_front [BINS];
  int m_back  [BINS];
  int m_peak  [BINS];
  logic [2:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         x;
    int         y;
    bit         av;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_rgb(input int x, input int y, input bit av);
    int bin, row;
    bin = y / (1 << BAR_SHIFT);
    row = y % (1 << BAR_SHIFT);
    if (!av || bin >= BINS || row == 0) return 3'b000;
`ifdef PEAK_HOLD_EN
    if (m_peak[bin] != 0 && x == (m_peak[bin] >> MAG_SHIFT)) return 3'b100;
`endif
    if (x < (m_front[bin] >> MAG_SHIFT)) return 3'b111;
    return 3'b000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < BINS; i++) begin
      m_front[i] = 0; m_back[i] = 0; m_peak[i] = 0;
    end
  endtask

  task automatic model_swap();
    int t;
    for (int i = 0; i < BINS; i++) begin
      t = m_front[i]; m_front[i] = m_back[i]; m_back[i] = t;
    end
`ifdef PEAK_HOLD_EN
    for (int i = 0; i < BINS; i++) begin
      t = m_peak[i] - DECAY;
      if (t < 0) t = 0;
      m_peak[i] = (m_front[i] > t) ? m_front[i] : t;
    end
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.vsync = i[0];
      bus12.vsync = i[0];
      tick();
      check("reset_rgb", {bus.r, bus.g, bus.b}, 3'b000);
      check("reset_swap_pulse", bus.swap_pulse, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_state", bus.dbg_state, 2'd0);
    end
    reset_n = 1'b1;
    bus.vsync = 1'b0;
    bus12.vsync = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic write_bin(input int a, input int m);
    bus.bin_wr = 1'b1;
    bus.bin_addr = a[AW-1:0];
    bus.bin_mag = m[MAG_W-1:0];
    tick();
    bus.bin_wr = 1'b0;
    if (a < BINS) m_back[a] = m;
  endtask

  task automatic do_swap(input bit wr_in_swap, input int wa, input int wm);
    int n_busy;
    bus.vsync = 1'b1;
    tick();
    check("swap_pulse_high", bus.swap_pulse, 1'b1);
    if (wr_in_swap) begin
      bus.bin_wr = 1'b1;
      bus.bin_addr = wa[AW-1:0];
      bus.bin_mag = wm[MAG_W-1:0];
    end
    model_swap();
    tick();
    bus.bin_wr = 1'b0;
    bus.vsync = 1'b0;
    if (wr_in_swap) m_back[wa] = wm;
    check("swap_pulse_one_cycle", bus.swap_pulse, 1'b0);
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) n_busy++;
      tick();
    end
    check("busy_cycles", n_busy, EXP_BUSY);
  endtask

  task automatic check_pixel(input string name, input int x, input int y, input bit av,
                             input logic [2:0] exp);
    bus.x_px = x[X_W-1:0];
    bus.y_px = y[Y_W-1:0];
    bus.activevideo = av;
    tick();
    tick();
    check(name, {bus.r, bus.g, bus.b}, exp);
    bus.activevideo = 1'b0;
  endtask

  task automatic px12(input string name, input int x, input int y, input logic [2:0] exp);
    bus12.x_px = x[X_W-1:0];
    bus12.y_px = y[Y_W-1:0];
    bus12.activevideo = 1'b1;
    tick();
    tick();
    check(name, {bus12.r, bus12.g, bus12.b}, exp);
    bus12.activevideo = 1'b0;
  endtask

  // One new pixel per cycle; each result is compared exactly two cycles later.
  task automatic stream_random(input int n);
    int x, y, bn;
    bit av;
    logic [2:0] e;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        y  = $urandom_range(0, 300);
        av = ($urandom_range(0, 4) != 0);
        bn = y >> BAR_SHIFT;
        x  = $urandom_range(0, 1023);
        if (bn < BINS && $urandom_range(0, 1) == 1) begin
          x = m_front[bn] + $urandom_range(0, 2) - 1;
`ifdef PEAK_HOLD_EN
          if ($urandom_range(0, 1) == 1) x = m_peak[bn];
`endif
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
        end
        bus.x_px = x[X_W-1:0];
        bus.y_px = y[Y_W-1:0];
        bus.activevideo = av;
        exp_q.push_back(exp_rgb(x, y, av));
      end else begin
        bus.activevideo = 1'b0;
      end
      tick();
      if (i >= 1) begin
        e = exp_q.pop_front();
        check("stream_pixel", {bus.r, bus.g, bus.b}, e);
      end
    end
  endtask

`ifdef PEAK_HOLD_EN
  task automatic pending_test();
    int n_pulse, busy_cnt, fall_at, pulse2_at;
    bit prev_busy;
    n_pulse = 0; busy_cnt = 0; fall_at = -1; pulse2_at = -1; prev_busy = 1'b0;
    bus.vsync = 1'b1;
    tick();
    for (int c = 0; c < 80; c++) begin
      if (bus.swap_pulse) begin
        n_pulse++;
        if (n_pulse == 2) pulse2_at = c;
      end
      if (bus.busy) busy_cnt++;
      if (prev_busy && !bus.busy && fall_at < 0) fall_at = c;
      prev_busy = bus.busy;
      if (c == 3 || c == 6) bus.vsync = 1'b0;
      if (c == 4 || c == 7) bus.vsync = 1'b1;
      tick();
    end
    bus.vsync = 1'b0;
    tick();
    model_swap();
    model_swap();
    check("pending_pulses", n_pulse, 2);
    check("pending_busy_total", busy_cnt, 2 * BINS);
    check("pending_pulse_after_busy", pulse2_at, fall_at + 1);
  endtask

  task automatic reset_mid_update();
    int cnt, old_peak;
    old_peak = m_peak[1];
    cnt = 0;
    bus.vsync = 1'b1;
    tick();
    for (int i = 0; i < 30 && cnt < 5; i++) begin
      if (bus.busy) cnt++;
      if (cnt < 5) tick();
    end
    check("reset_mid_reached_5th", cnt, 5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.vsync = 1'b0;
    tick();
    model_clear();
    check("mid_reset_state_idle", bus.dbg_state, 2'd0);
    check("mid_reset_busy", bus.busy, 1'b0);
    check_pixel("mid_reset_old_peak_black", old_peak, 17, 1'b1, 3'b000);
    check_pixel("mid_reset_old_peak_m1", old_peak - 1, 17, 1'b1, 3'b000);
    stream_random(30);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bus.x_px = '0; bus.y_px = '0; bus.activevideo = 1'b0; bus.vsync = 1'b0;
    bus.bin_wr = 1'b0; bus.bin_addr = '0; bus.bin_mag = '0;
    bus12.x_px = '0; bus12.y_px = '0; bus12.activevideo = 1'b0; bus12.vsync = 1'b0;
    bus12.bin_wr = 1'b0; bus12.bin_addr = '0; bus12.bin_mag = '0;

    // Display after bin 2 = 100 is swapped in, everything else empty.
    tbl[0] = '{99,  40, 1'b1, 3'b111};
`ifdef PEAK_HOLD_EN
    tbl[1] = '{100, 40, 1'b1, 3'b100};
`else
    tbl[1] = '{100, 40, 1'b1, 3'b000};
`endif
    tbl[2] = '{99,  32, 1'b1, 3'b000};
    tbl[3] = '{0,   33, 1'b1, 3'b111};
    tbl[4] = '{99,  47, 1'b1, 3'b111};
    tbl[5] = '{50,  40, 1'b0, 3'b000};
    tbl[6] = '{0,   48, 1'b1, 3'b000};
    tbl[7] = '{0,   24, 1'b1, 3'b000};

    do_reset();
    stream_random(40);

    // Out-of-range address on a 12-bin instance
    bus12.bin_wr = 1'b1; bus12.bin_addr = 4'd12; bus12.bin_mag = 16'd500;
    tick();
    bus12.bin_addr = 4'd11; bus12.bin_mag = 16'd20;
    tick();
    bus12.bin_wr = 1'b0;
    bus12.vsync = 1'b1;
    tick(); tick();
    bus12.vsync = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    px12("b12_bin11_x19", 19, 177, 3'b111);
    px12("b12_bin11_x21", 21, 177, 3'b000);
    px12("b12_bin0_empty", 5, 1, 3'b000);
    px12("b12_bin0_x0", 0, 2, 3'b000);

    // Double buffering
    write_bin(2, 100);
    check_pixel("pre_swap_r40_x99", 99, 40, 1'b1, 3'b000);
    do_swap(1'b0, 0, 0);
    for (int i = 0; i < 8; i++)
      check_pixel($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].av, tbl[i].exp);

    // Write during the swap cycle goes to the new back bank
    do_swap(1'b1, 0, 50);
    check_pixel("swap_wr_hidden", 10, 1, 1'b1, 3'b000);
    do_swap(1'b0, 0, 0);
    check_pixel("swap_wr_shown_x10", 10, 1, 1'b1, 3'b111);
    check_pixel("swap_wr_shown_x49", 49, 1, 1'b1, 3'b111);
    check_pixel("swap_wr_shown_x51", 51, 1, 1'b1, 3'b000);

    // Boundaries
    write_bin(3, 16'hFFFF);
    do_swap(1'b0, 0, 0);
    check_pixel("full_width_bar", 1023, 49, 1'b1, 3'b111);
    check_pixel("bin16_black", 1023, 257, 1'b1, 3'b000);
    check_pixel("bin63_black", 0, 1023, 1'b1, 3'b000);

    // Randomized frames against the model
    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++)
        write_bin($urandom_range(0, BINS - 1),
                  ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 1100));
      do_swap($urandom_range(0, 1) == 1, $urandom_range(0, BINS - 1), $urandom_range(0, 1023));
      stream_random(60);
    end

`ifdef PEAK_HOLD_EN
    do_reset();
    write_bin(1, 200);
    do_swap(1'b0, 0, 0);
    check_pixel("peak_first_200", 200, 17, 1'b1, 3'b100);
    check_pixel("bar_first_199", 199, 17, 1'b1, 3'b111);
    for (int f = 0; f < 3; f++) begin
      write_bin(1, 10);
      do_swap(1'b0, 0, 0);
      check_pixel($sformatf("peak_decay_f%0d", f), 199 - f, 17, 1'b1, 3'b100);
      check_pixel("peak_bar_end_x9", 9, 17, 1'b1, 3'b111);
      check_pixel("peak_bar_end_x10", 10, 17, 1'b1, 3'b000);
    end
    stream_random(40);
    pending_test();
    stream_random(40);
    reset_mid_update();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
